wb_rr_arbiter: RTL and testbench
================================

// Module: wb_rr_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone classic arbiter that shares the SPI SRAM port.
//  Masters are the UART bridge and the Levenshtein controller's master port.
//  Round-robin grant, held for the whole cyc; one idle cycle between owners.
//  Bus watchdog: aborts a hung slave access with err so the owner cannot lock the port.
// PARAMETERS
//  ADDR_WIDTH      22   address width of masters and slave
//  DATA_WIDTH      8    data width
//  TIMEOUT_CYCLES  255  stb cycles without ack/err/rty before abort; 0 disables the watchdog
//  TIMEOUT_WIDTH   8    watchdog counter width; must hold TIMEOUT_CYCLES
// PORTS
//  clk_i        in   1           clock
//  rst_i        in   1           synchronous reset, active high
//  wbmN_cyc_i   in   1           master N cycle request, N=0,1
//  wbmN_stb_i   in   1           master N strobe
//  wbmN_we_i    in   1           master N write enable
//  wbmN_adr_i   in   ADDR_WIDTH  master N address
//  wbmN_dat_i   in   DATA_WIDTH  master N write data
//  wbmN_ack_o   out  1           master N ack
//  wbmN_err_o   out  1           master N err (slave err or watchdog abort)
//  wbmN_rty_o   out  1           master N retry
//  wbmN_dat_o   out  DATA_WIDTH  read data, wbs_dat_i broadcast to both masters
//  wbs_cyc_o    out  1           slave cycle
//  wbs_stb_o    out  1           slave strobe
//  wbs_we_o     out  1           slave write enable
//  wbs_adr_o    out  ADDR_WIDTH  slave address
//  wbs_dat_o    out  DATA_WIDTH  slave write data
//  wbs_ack_i    in   1           slave ack
//  wbs_err_i    in   1           slave err
//  wbs_rty_i    in   1           slave retry
//  wbs_dat_i    in   DATA_WIDTH  slave read data
//  grant_o      out  2           one-hot current owner; 00 when idle or aborting
// BEHAVIOUR
//  - Reset: state IDLE, last_owner=1 so master 0 wins the first tie, watchdog=0.
//    All wbs_* outputs, ack/err/rty and grant_o are 0.
//  - FSM IDLE -> OWN0/OWN1 -> IDLE; OWNn -> ABORT -> IDLE.
//  - IDLE picks the owner from the registered state, so the grant appears the cycle
//    after cyc is seen (1 cycle arbitration latency):
//    - only one cyc asserted: grant that master;
//    - both asserted: grant the master != last_owner; last_owner updates on grant.
//  - OWNn: wbs_cyc/stb/we/adr/dat_o combinationally follow master n (zero-latency passthrough).
//    ack/err/rty are routed only to master n; the other master sees 0 ack/err/rty.
//  - IDLE/ABORT: all wbs_* control/address/data outputs are 0.
//  - OWNn -> IDLE on the edge where wbmn_cyc_i=0. That cycle the slave already sees cyc=0.
//    Always at least one IDLE cycle before the next grant, even if the other master waits.
//  - Owner dropping cyc mid-strobe abandons the access. A late slave ack in IDLE is discarded.
//  - Multi-beat: while owner holds cyc, back-to-back stb beats pass through with no gaps.
//  - Watchdog:
//    - counts cycles with wbs_stb_o=1 and none of ack/err/rty;
//    - clears on any termination, on stb low, and in IDLE.
//    - When count==TIMEOUT_CYCLES-1 and still no termination: that cycle the arbiter drives
//      errn_o=1 to the owner instead of waiting; next state ABORT.
//  - ABORT: slave sees cyc=stb=0; stay until owner drops cyc, then IDLE. Further owner stb
//    in ABORT gets err=1 each cycle (no slave access).
//  - Simultaneous slave termination and timeout: the slave termination wins; no abort.
//  - rst_i mid-transaction: next edge forces IDLE; wbs_cyc_o low that same following cycle.
//  - TIMEOUT_CYCLES=0: watchdog logic is removed and ABORT is unreachable.
// TESTING
//  - Single master: m1 read adr=0x000123, slave ack after 3 cycles with dat=0xA5 ->
//    grant_o=10 one cycle after cyc; m1 gets ack + 0xA5; m0 sees no ack.
//  - Tie from reset: both cyc in the same cycle -> m0 granted first; m1 granted after m0
//    drops cyc + 1 IDLE cycle.
//  - Round-robin: next tie after that -> m0 granted. Sustained m0 requests never starve m1.
//  - Burst: m0 holds cyc, 4 writes 0x11..0x44 with slave ack each cycle -> 4 beats on the
//    slave with no gap; m1 request held off until m0 releases.
//  - Watchdog: TIMEOUT_CYCLES=8, slave never acks -> after 8 stb cycles owner gets one err
//    pulse and wbs_cyc_o drops; after owner releases, m1 is served normally.
//  - Reset mid-access: rst_i for 1 cycle during m0 stb -> wbs_cyc_o=0, grant_o=00 next cycle;
//    next tie goes to m0.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Two-master / one-slave Wishbone classic arbiter in front of the SPI SRAM
//   port. Round-robin grant held for a whole cyc, one IDLE cycle between
//   owners, and a bus watchdog that aborts a hung slave access with err.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   wbmN_cyc/stb/we/adr/dat_i   master N request (N = 0, 1)
//   wbmN_ack/err/rty_o    master N termination (only the owner sees them)
//   wbmN_dat_o            slave read data, broadcast to both masters
//   wbs_cyc/stb/we/adr/dat_o    slave request, passthrough of the owner
//   wbs_ack/err/rty_i, wbs_dat_i  slave response
//   grant_o               one-hot owner, 00 when idle or aborting
module wb_rr_arbiter #(
  parameter int ADDR_WIDTH     = 22,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wbm0_cyc_i,
  input  logic                  wbm0_stb_i,
  input  logic                  wbm0_we_i,
  input  logic [ADDR_WIDTH-1:0] wbm0_adr_i,
  input  logic [DATA_WIDTH-1:0] wbm0_dat_i,
  output logic                  wbm0_ack_o,
  output logic                  wbm0_err_o,
  output logic                  wbm0_rty_o,
  output logic [DATA_WIDTH-1:0] wbm0_dat_o,
  input  logic                  wbm1_cyc_i,
  input  logic                  wbm1_stb_i,
  input  logic                  wbm1_we_i,
  input  logic [ADDR_WIDTH-1:0] wbm1_adr_i,
  input  logic [DATA_WIDTH-1:0] wbm1_dat_i,
  output logic                  wbm1_ack_o,
  output logic                  wbm1_err_o,
  output logic                  wbm1_rty_o,
  output logic [DATA_WIDTH-1:0] wbm1_dat_o,
  output logic                  wbs_cyc_o,
  output logic                  wbs_stb_o,
  output logic                  wbs_we_o,
  output logic [ADDR_WIDTH-1:0] wbs_adr_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o,
  input  logic                  wbs_ack_i,
  input  logic                  wbs_err_i,
  input  logic                  wbs_rty_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  output logic [1:0]            grant_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN0  = 2'd1;
  localparam logic [1:0] S_OWN1  = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  typedef struct packed {
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [DATA_WIDTH-1:0] dat;
  } wb_req_t;

  wb_req_t [1:0] req;
  wb_req_t       cur;
  wb_req_t       bus;

  logic [1:0] state, state_nxt;
  // owner doubles as last_owner: it is written only on a grant and keeps
  // naming the master through OWNn and ABORT.
  logic       owner, owner_nxt;
  logic       owned;
  logic       term;
  logic       timeout_hit;
  logic       pick;
  logic [1:0] ack_v, err_v, rty_v;

  assign req[0] = {wbm0_cyc_i, wbm0_stb_i, wbm0_we_i, wbm0_adr_i, wbm0_dat_i};
  assign req[1] = {wbm1_cyc_i, wbm1_stb_i, wbm1_we_i, wbm1_adr_i, wbm1_dat_i};
  assign cur    = req[owner];
  assign owned  = (state == S_OWN0) || (state == S_OWN1);
  assign term   = wbs_ack_i | wbs_err_i | wbs_rty_i;

  // Zero-latency passthrough of the owner; everything low otherwise.
  assign bus       = owned ? cur : '0;
  assign wbs_cyc_o = bus.cyc;
  assign wbs_stb_o = bus.stb;
  assign wbs_we_o  = bus.we;
  assign wbs_adr_o = bus.adr;
  assign wbs_dat_o = bus.dat;

  assign wbm0_dat_o = wbs_dat_i;
  assign wbm1_dat_o = wbs_dat_i;
  assign grant_o    = {state == S_OWN1, state == S_OWN0};

  always_comb begin
    ack_v = '0;
    err_v = '0;
    rty_v = '0;
    if (owned) begin
      ack_v[owner] = wbs_ack_i;
      err_v[owner] = wbs_err_i | timeout_hit;
      rty_v[owner] = wbs_rty_i;
    end else if (state == S_ABORT) begin
      // Port is fenced off: every further strobe is refused immediately.
      err_v[owner] = cur.stb;
    end
  end

  assign wbm0_ack_o = ack_v[0];
  assign wbm0_err_o = err_v[0];
  assign wbm0_rty_o = rty_v[0];
  assign wbm1_ack_o = ack_v[1];
  assign wbm1_err_o = err_v[1];
  assign wbm1_rty_o = rty_v[1];

  // On a tie the master that did not own the port last time wins.
  assign pick = (req[0].cyc && req[1].cyc) ? ~owner : req[1].cyc;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      S_IDLE: begin
        if (req[0].cyc || req[1].cyc) begin
          owner_nxt = pick;
          state_nxt = pick ? S_OWN1 : S_OWN0;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!cur.cyc)         state_nxt = S_IDLE;
        else if (timeout_hit) state_nxt = S_ABORT;
      end
      S_ABORT: begin
        if (!cur.cyc) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      owner <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wdog
      localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
      logic [TIMEOUT_WIDTH-1:0] wdog;
      logic                     stall;

      // A stalled strobe cycle; a slave termination on the last allowed
      // cycle wins over the abort because it is excluded here.
      assign stall       = owned & cur.stb & ~term;
      assign timeout_hit = stall && (wdog == WD_LAST);

      always_ff @(posedge clk_i) begin
        if (rst_i)                    wdog <= '0;
        else if (stall && !timeout_hit) wdog <= wdog + 1'b1;
        else                          wdog <= '0;
      end
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int AW = 22;
  localparam int DW = 8;
  localparam int TO = 8;
  localparam int TW = 8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         mc = '0, ms = '0, mw = '0;
  logic [1:0][AW-1:0] ma = '0;
  logic [1:0][DW-1:0] md = '0;
  logic               s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
  logic [DW-1:0]      s_dat = '0;

  wire          m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  wire [DW-1:0] m0_dat, m1_dat;
  wire          wbs_cyc, wbs_stb, wbs_we;
  wire [AW-1:0] wbs_adr;
  wire [DW-1:0] wbs_dat;
  wire [1:0]    gnt;
  wire [1:0]    mack = {m1_ack, m0_ack};
  wire [1:0]    merr = {m1_err, m0_err};
  wire [1:0]    mrty = {m1_rty, m0_rty};

  wb_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(TW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wbm0_cyc_i(mc[0]), .wbm0_stb_i(ms[0]), .wbm0_we_i(mw[0]), .wbm0_adr_i(ma[0]), .wbm0_dat_i(md[0]),
    .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty), .wbm0_dat_o(m0_dat),
    .wbm1_cyc_i(mc[1]), .wbm1_stb_i(ms[1]), .wbm1_we_i(mw[1]), .wbm1_adr_i(ma[1]), .wbm1_dat_i(md[1]),
    .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty), .wbm1_dat_o(m1_dat),
    .wbs_cyc_o(wbs_cyc), .wbs_stb_o(wbs_stb), .wbs_we_o(wbs_we), .wbs_adr_o(wbs_adr), .wbs_dat_o(wbs_dat),
    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty), .wbs_dat_i(s_dat),
    .grant_o(gnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Who owns the port (if anyone), whether the owner is fenced off after a
  // timeout, who won last, and how many strobe cycles have gone unanswered.
  bit          chk_en = 1'b0;
  bit          o_v = 1'b0;
  bit          o_abort = 1'b0;
  logic        o_id = 1'b1;
  logic        o_last = 1'b1;
  int          o_stall = 0;
  logic [32:0] e_bus;
  logic [1:0]  e_ack, e_err, e_rty, e_gnt;
  bit          e_term, e_tmo;

  always @(negedge clk) begin
    e_bus = '0; e_ack = '0; e_err = '0; e_rty = '0; e_gnt = '0; e_tmo = 1'b0;
    e_term = s_ack | s_err | s_rty;
    if (o_v && !o_abort) begin
      e_bus = {mc[o_id], ms[o_id], mw[o_id], ma[o_id], md[o_id]};
      e_tmo = (TO > 0) && ms[o_id] && !e_term && (o_stall == TO - 1);
      e_ack[o_id] = s_ack;
      e_err[o_id] = s_err | e_tmo;
      e_rty[o_id] = s_rty;
      e_gnt[o_id] = 1'b1;
    end else if (o_v) begin
      e_err[o_id] = ms[o_id];
    end
    if (chk_en) begin
      chk("m_grant", 64'(gnt), 64'(e_gnt));
      chk("m_wbs", 64'({wbs_cyc, wbs_stb, wbs_we, wbs_adr, wbs_dat}), 64'(e_bus));
      chk("m_resp_m0", 64'({m0_ack, m0_err, m0_rty}), 64'({e_ack[0], e_err[0], e_rty[0]}));
      chk("m_resp_m1", 64'({m1_ack, m1_err, m1_rty}), 64'({e_ack[1], e_err[1], e_rty[1]}));
      chk("m_rdata", 64'({m0_dat, m1_dat}), 64'({s_dat, s_dat}));
    end
    // advance to the state after the coming rising edge
    if (rst_i) begin
      o_v = 1'b0; o_abort = 1'b0; o_last = 1'b1; o_stall = 0;
      chk_en = 1'b1;
    end else if (!o_v) begin
      o_stall = 0;
      if (mc != 2'b00) begin
        o_id   = (mc == 2'b11) ? ~o_last : mc[1];
        o_last = o_id;
        o_v    = 1'b1;
      end
    end else if (o_abort) begin
      o_stall = 0;
      if (!mc[o_id]) begin o_v = 1'b0; o_abort = 1'b0; end
    end else begin
      o_stall = (ms[o_id] && !e_term && !e_tmo) ? o_stall + 1 : 0;
      if (!mc[o_id]) o_v = 1'b0;
      else if (e_tmo) begin o_abort = 1'b1; o_stall = 0; end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    mc = '0; ms = '0; mw = '0;
    s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
  endtask

  logic [1:0] sa, se, sr, sst;
  logic       sl_stb, sl_term;
  bit   [1:0] act = '0;
  int         beats [2];
  int         lin [2];
  int         scnt = 0, lat = 0, kind = 0;
  logic [7:0] bv;

  task automatic new_beat(input int i);
    mw[i] = 1'($urandom_range(0, 1));
    ma[i] = AW'($urandom);
    md[i] = DW'($urandom);
  endtask

  task automatic drop(input int i);
    mc[i] = 1'b0; ms[i] = 1'b0; act[i] = 1'b0;
  endtask

  initial begin
    idle_all();
    rst_i = 1'b1;
    repeat (3) step();
    rst_i = 1'b0;
    #2;
    chk("rst_grant", 64'(gnt), 64'd0);
    chk("rst_wbs_ctl", 64'({wbs_cyc, wbs_stb, wbs_we}), 64'd0);
    chk("rst_resp", 64'({mack, merr, mrty}), 64'd0);

    // single master read, slave answers on the third granted cycle
    mc[1] = 1'b1; ms[1] = 1'b1; mw[1] = 1'b0; ma[1] = 22'h000123;
    #1 chk("a_arb_latency", 64'(gnt), 64'b00);
    step(); #2;
    chk("a_grant", 64'(gnt), 64'b10);
    chk("a_adr", 64'(wbs_adr), 64'h123);
    step(); step();
    s_ack = 1'b1; s_dat = 8'hA5; #2;
    chk("a_m1_ack", 64'(m1_ack), 64'd1);
    chk("a_m1_dat", 64'(m1_dat), 64'hA5);
    chk("a_m0_ack", 64'(m0_ack), 64'd0);
    step();
    mc[1] = 1'b0; ms[1] = 1'b0; s_ack = 1'b0; #2;
    chk("a_release_cyc", 64'(wbs_cyc), 64'd0);
    step(); #2;
    chk("a_idle", 64'(gnt), 64'd0);

    // tie straight out of reset
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    mc = 2'b11; ms = 2'b11; ma[0] = 22'h10; ma[1] = 22'h20;
    step(); #2;
    chk("b_tie_m0", 64'(gnt), 64'b01);
    s_ack = 1'b1;
    step();
    mc[0] = 1'b0; ms[0] = 1'b0; s_ack = 1'b0; #2;
    chk("b_drop_cyc", 64'(wbs_cyc), 64'd0);
    step(); #2;
    chk("b_idle_gap", 64'(gnt), 64'd0);
    step(); #2;
    chk("b_m1", 64'(gnt), 64'b10);
    s_ack = 1'b1;
    step();
    mc[1] = 1'b0; ms[1] = 1'b0; s_ack = 1'b0;
    step();

    // next tie goes back to m0, then m1
    mc = 2'b11; ms = 2'b11;
    step(); #2;
    chk("rr_m0", 64'(gnt), 64'b01);
    s_ack = 1'b1;
    step();
    mc[0] = 1'b0; ms[0] = 1'b0; s_ack = 1'b0;
    step(); step(); #2;
    chk("rr_m1", 64'(gnt), 64'b10);
    mc[1] = 1'b0; ms[1] = 1'b0;
    step(); step();

    // four-beat write burst from m0 while m1 waits
    mc = 2'b11; ms = 2'b11; mw[0] = 1'b1; md[0] = 8'h11;
    step(); #2;
    chk("burst_grant", 64'(gnt), 64'b01);
    s_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bv = 8'(8'h11 * (k + 1));
      if (k > 0) begin step(); md[0] = bv; end
      #2;
      chk("burst_beat", 64'({wbs_cyc, wbs_stb, wbs_we, wbs_dat}), 64'({3'b111, bv}));
      chk("burst_ack", 64'({m1_ack, m0_ack}), 64'b01);
    end
    step();
    mc[0] = 1'b0; ms[0] = 1'b0; mw[0] = 1'b0; s_ack = 1'b0;
    step(); #2;
    chk("burst_m1_held", 64'(gnt), 64'b00);
    step(); #2;
    chk("burst_m1_grant", 64'(gnt), 64'b10);
    mc[1] = 1'b0; ms[1] = 1'b0;
    step(); step();

    // watchdog: slave never answers
    mc[0] = 1'b1; ms[0] = 1'b1;
    step();
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) step();
      #2;
      if (n == 7) chk("wd_no_err_early", 64'(m0_err), 64'd0);
      if (n == 8) begin
        chk("wd_err", 64'(m0_err), 64'd1);
        chk("wd_cyc_before", 64'(wbs_cyc), 64'd1);
      end
    end
    mc[1] = 1'b1; ms[1] = 1'b1;
    step(); #2;
    chk("wd_abort_cyc", 64'(wbs_cyc), 64'd0);
    chk("wd_abort_grant", 64'(gnt), 64'd0);
    chk("wd_abort_err", 64'({m1_err, m0_err}), 64'b01);
    mc[0] = 1'b0; ms[0] = 1'b0;
    step(); step(); #2;
    chk("wd_m1_served", 64'(gnt), 64'b10);
    s_ack = 1'b1; s_dat = 8'h5A; #1;
    chk("wd_m1_ack", 64'({m1_ack, m1_dat}), 64'h15A);
    step();
    mc[1] = 1'b0; ms[1] = 1'b0; s_ack = 1'b0;
    step(); step();

    // reset during an m0 access
    mc[0] = 1'b1; ms[0] = 1'b1;
    step(); #2;
    chk("rm_grant", 64'(gnt), 64'b01);
    mc[1] = 1'b1; ms[1] = 1'b1; rst_i = 1'b1;
    step();
    rst_i = 1'b0; #2;
    chk("rm_cyc", 64'(wbs_cyc), 64'd0);
    chk("rm_grant0", 64'(gnt), 64'd0);
    step(); #2;
    chk("rm_tie_m0", 64'(gnt), 64'b01);
    idle_all();
    step(); step(); step();

    // randomized traffic against the model
    lin[0] = 0; lin[1] = 0; beats[0] = 0; beats[1] = 0;
    for (int cn = 0; cn < 4000; cn++) begin
      @(negedge clk);
      sa = mack; se = merr; sr = mrty; sst = ms;
      sl_stb = wbs_stb; sl_term = s_ack | s_err | s_rty;
      @(posedge clk); #1;
      rst_i = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 2; i++) begin
        if (act[i]) begin
          if (lin[i] > 0) begin
            lin[i]--;
            if (lin[i] == 0) drop(i);
          end else if (sst[i] && (se[i] || sr[i])) begin
            if ($urandom_range(0, 3) == 0) lin[i] = $urandom_range(1, 2);
            else drop(i);
          end else if (sst[i] && sa[i]) begin
            beats[i]--;
            if (beats[i] == 0) drop(i);
            else begin new_beat(i); ms[i] = ($urandom_range(0, 3) != 0); end
          end else if (!ms[i]) begin
            ms[i] = 1'b1;
          end else if ($urandom_range(0, 79) == 0) begin
            drop(i);
          end
        end else if ($urandom_range(0, 2) == 0) begin
          act[i] = 1'b1; beats[i] = $urandom_range(1, 4);
          mc[i] = 1'b1; ms[i] = 1'b1; new_beat(i);
        end
      end
      #1;
      if (sl_stb && !sl_term) scnt++;
      else begin
        scnt = 0;
        case ($urandom_range(0, 15))
          0:       lat = 99;
          1:       lat = 7;
          default: lat = $urandom_range(0, 3);
        endcase
        kind = $urandom_range(0, 9);
      end
      s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      if (wbs_stb && scnt >= lat) begin
        if (kind == 0)      s_err = 1'b1;
        else if (kind == 1) s_rty = 1'b1;
        else                s_ack = 1'b1;
      end else if (!wbs_stb && $urandom_range(0, 59) == 0) begin
        s_ack = 1'b1;
      end
      s_dat = DW'($urandom);
    end
    rst_i = 1'b0;
    idle_all();
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
